// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges the execute, load-completion and debug writers onto
// the single write port of the 32 x 32 integer register bank. It also keeps the
// outstanding-load scoreboard for the decode hazard check. Debug accesses halt
// the core and borrow the rs2 read port for reads.
module regfile_wb_arbiter #(
    parameter int BANK_WIDTH     = 5,
    parameter int REGISTER_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_wr_valid,
    input  logic [BANK_WIDTH-1:0]     ex_wr_sel,
    input  logic [REGISTER_WIDTH-1:0] ex_wr_data,
    input  logic                      ld_issue,
    input  logic [BANK_WIDTH-1:0]     ld_issue_sel,
    input  logic                      ld_done_valid,
    input  logic [BANK_WIDTH-1:0]     ld_done_sel,
    input  logic [REGISTER_WIDTH-1:0] ld_done_data,
    output logic                      ld_done_ready,
    input  logic [BANK_WIDTH-1:0]     dec_rs1,
    input  logic [BANK_WIDTH-1:0]     dec_rs2,
    input  logic [BANK_WIDTH-1:0]     dec_rd,
    output logic                      hazard,
    input  logic [BANK_WIDTH-1:0]     core_rs2_sel,
    output logic [BANK_WIDTH-1:0]     bank_rs2_sel,
    input  logic [REGISTER_WIDTH-1:0] bank_rs2_data,
    output logic                      reg_w,
    output logic [BANK_WIDTH-1:0]     rd_sel,
    output logic [REGISTER_WIDTH-1:0] rd_data,
    input  logic                      dbg_req,
    input  logic                      dbg_we,
    input  logic [BANK_WIDTH-1:0]     dbg_sel,
    input  logic [REGISTER_WIDTH-1:0] dbg_wdata,
    output logic                      dbg_ack,
    output logic [REGISTER_WIDTH-1:0] dbg_rdata,
    output logic                      core_halt
);

    localparam int SIZE = 2 ** BANK_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state;
    logic [SIZE-1:0] busy;
    logic [SIZE-1:0] busy_next;
    logic            ld_accept;
    logic            dbg_grant;

    // Load completion gets the port only when execute is idle and no debug
    // access is in flight; the load source holds its request until accepted.
    assign ld_done_ready = rst & ~ex_wr_valid & (state == IDLE);
    assign ld_accept     = ld_done_valid & ld_done_ready;

    // Hazard uses registered busy only, so a clear shows up one cycle late.
    assign hazard = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

    assign bank_rs2_sel = (state == ACCESS) ? dbg_sel : core_rs2_sel;
    assign core_halt    = dbg_req | (state != IDLE);

    // Debug may only start once the pipeline has drained: no loads pending and
    // no writer competing for the port in the cycle before ACCESS.
    assign dbg_grant = dbg_req & (busy == '0) & ~ex_wr_valid & ~ld_done_valid;

    // Write-port priority mux: execute, then load, then debug write
    always_comb begin
        reg_w   = 1'b0;
        rd_sel  = ex_wr_sel;
        rd_data = ex_wr_data;
        if (ex_wr_valid) begin
            reg_w = 1'b1;
        end else if (ld_accept) begin
            reg_w   = 1'b1;
            rd_sel  = ld_done_sel;
            rd_data = ld_done_data;
        end else if ((state == ACCESS) && dbg_we) begin
            reg_w   = 1'b1;
            rd_sel  = dbg_sel;
            rd_data = dbg_wdata;
        end
        // x0 is hardwired; the transaction still completes, it just never writes.
        if (!rst || (rd_sel == '0)) begin
            reg_w = 1'b0;
        end
    end

    // Next scoreboard value: a new issue overrides a same-cycle completion
    always_comb begin
        busy_next = busy;
        if (ld_accept) begin
            busy_next[ld_done_sel] = 1'b0;
        end
        if (ld_issue) begin
            busy_next[ld_issue_sel] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Debug sequencer with registered ack and read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (dbg_grant) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!dbg_we) begin
                        dbg_rdata <= (dbg_sel == '0) ? '0 : bank_rs2_data;
                    end
                    dbg_ack <= 1'b1;
                    state   <= ACK;
                end
                ACK: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    // One access per request level: wait for the requester to drop.
                    if (!dbg_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Expected bank writes and debug
// acknowledges are queued by the stimulus and consumed by a monitor whenever the
// DUT asserts reg_w or dbg_ack. Level checks cover ready, hazard, halt and rs2 select.
module tb_regfile_wb_arbiter;

    localparam int BW = 5;
    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_wr_valid;
    logic [BW-1:0] ex_wr_sel;
    logic [RW-1:0] ex_wr_data;
    logic          ld_issue;
    logic [BW-1:0] ld_issue_sel;
    logic          ld_done_valid;
    logic [BW-1:0] ld_done_sel;
    logic [RW-1:0] ld_done_data;
    logic          ld_done_ready;
    logic [BW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic          hazard;
    logic [BW-1:0] core_rs2_sel;
    logic [BW-1:0] bank_rs2_sel;
    logic [RW-1:0] bank_rs2_data;
    logic          reg_w;
    logic [BW-1:0] rd_sel;
    logic [RW-1:0] rd_data;
    logic          dbg_req, dbg_we;
    logic [BW-1:0] dbg_sel;
    logic [RW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [RW-1:0] dbg_rdata;
    logic          core_halt;

    typedef struct packed {
        logic [BW-1:0] sel;
        logic [RW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic          rd;
        logic [RW-1:0] data;
    } ack_t;

    wr_t  wq[$];
    ack_t aq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [RW-1:0] bank [0:31];

    regfile_wb_arbiter #(.BANK_WIDTH(BW), .REGISTER_WIDTH(RW)) dut (
        .clk(clk), .rst(rst),
        .ex_wr_valid(ex_wr_valid), .ex_wr_sel(ex_wr_sel), .ex_wr_data(ex_wr_data),
        .ld_issue(ld_issue), .ld_issue_sel(ld_issue_sel),
        .ld_done_valid(ld_done_valid), .ld_done_sel(ld_done_sel),
        .ld_done_data(ld_done_data), .ld_done_ready(ld_done_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .hazard(hazard),
        .core_rs2_sel(core_rs2_sel), .bank_rs2_sel(bank_rs2_sel),
        .bank_rs2_data(bank_rs2_data),
        .reg_w(reg_w), .rd_sel(rd_sel), .rd_data(rd_data),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_sel(dbg_sel), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .core_halt(core_halt)
    );

    always #5 clk = ~clk;

    // Register bank model driven by the arbiter's write port
    initial begin
        for (int i = 0; i < 32; i++) bank[i] = '0;
    end

    always @(posedge clk) begin
        if (reg_w) bank[rd_sel] <= rd_data;
    end

    always_comb begin
        bank_rs2_data = (bank_rs2_sel == '0) ? '0 : bank[bank_rs2_sel];
    end

    // Monitor: every write and every ack must match the next queued expectation
    always @(negedge clk) begin
        if (reg_w) begin
            vectors++;
            if (wq.size() == 0) begin
                miscompares++;
                $display("FAIL write: unexpected reg_w sel=%0d data=0x%0h, none expected", rd_sel, rd_data);
            end else begin
                wr_t e;
                e = wq.pop_front();
                if (rd_sel !== e.sel || rd_data !== e.data) begin
                    miscompares++;
                    $display("FAIL write: got sel=%0d data=0x%0h expected sel=%0d data=0x%0h",
                             rd_sel, rd_data, e.sel, e.data);
                end
            end
        end
        if (dbg_ack) begin
            vectors++;
            if (aq.size() == 0) begin
                miscompares++;
                $display("FAIL dbg_ack: unexpected ack (rdata=0x%0h), none expected", dbg_rdata);
            end else begin
                ack_t a;
                a = aq.pop_front();
                if (a.rd && dbg_rdata !== a.data) begin
                    miscompares++;
                    $display("FAIL dbg_rdata: got 0x%0h expected 0x%0h", dbg_rdata, a.data);
                end
            end
        end
    end

    // Protocol check: no execute or load writer may be active during ACCESS
    always @(posedge clk) begin
        if (rst === 1'b1 && dut.state == 2'd1 && (ex_wr_valid || ld_done_valid)) begin
            miscompares++;
            $display("FAIL protocol: writer active during debug ACCESS ex=%0b ld=%0b required 0",
                     ex_wr_valid, ld_done_valid);
        end
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic expect_wr(input logic [BW-1:0] sel, input logic [RW-1:0] data);
        wq.push_back({sel, data});
    endtask

    // One full debug transaction started with the grant condition already true
    task automatic dbg_op(input logic we, input logic [BW-1:0] sel,
                          input logic [RW-1:0] wdata, input logic [RW-1:0] rexp);
        tick();
        dbg_req = 1'b1; dbg_we = we; dbg_sel = sel; dbg_wdata = wdata;
        aq.push_back({~we, rexp});
        mid();
        check("dbg_halt_req", {31'd0, core_halt}, 1);
        tick();
        if (we && sel != '0) expect_wr(sel, wdata);
        mid();
        check("dbg_acc_rs2sel", {27'd0, bank_rs2_sel}, {27'd0, sel});
        check("dbg_acc_regw", {31'd0, reg_w}, {31'd0, (we && sel != '0)});
        tick();
        mid();
        check("dbg_ack_pulse", {31'd0, dbg_ack}, 1);
        tick();
        dbg_req = 1'b0;
        mid();
        check("dbg_ack_drop", {31'd0, dbg_ack}, 0);
        tick();
        mid();
        check("dbg_halt_release", {31'd0, core_halt}, 0);
    endtask

    initial begin
        rst = 1'b0;
        ex_wr_valid = 0; ex_wr_sel = '0; ex_wr_data = '0;
        ld_issue = 0; ld_issue_sel = '0;
        ld_done_valid = 0; ld_done_sel = '0; ld_done_data = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; core_rs2_sel = '0;
        dbg_req = 0; dbg_we = 0; dbg_sel = '0; dbg_wdata = '0;

        // Reset behaviour
        tick();
        ld_done_valid = 1; ld_done_sel = 5'd2; ld_done_data = 32'h22;
        mid();
        check("rst_ld_ready", {31'd0, ld_done_ready}, 0);
        check("rst_regw_ld", {31'd0, reg_w}, 0);
        tick();
        ld_done_valid = 0; ex_wr_valid = 1; ex_wr_sel = 5'd5; ex_wr_data = 32'hBAD;
        mid();
        check("rst_regw_ex", {31'd0, reg_w}, 0);
        check("rst_ack", {31'd0, dbg_ack}, 0);
        check("rst_rdata", dbg_rdata, 0);
        check("rst_halt", {31'd0, core_halt}, 0);

        // Execute writeback, then execute to x0
        tick();
        rst = 1; ex_wr_sel = 5'd5; ex_wr_data = 32'h1234;
        expect_wr(5'd5, 32'h1234);
        mid();
        check("ex_regw", {31'd0, reg_w}, 1);
        tick();
        ex_wr_sel = 5'd0; ex_wr_data = 32'hDEAD;
        mid();
        check("ex_x0_regw", {31'd0, reg_w}, 0);

        // Load issue, blocked completion, retry, hazard clear one cycle later
        tick();
        ex_wr_valid = 0; ld_issue = 1; ld_issue_sel = 5'd7; dec_rs1 = 5'd7;
        mid();
        check("ld_hz_before", {31'd0, hazard}, 0);
        tick();
        ld_issue = 0;
        ld_done_valid = 1; ld_done_sel = 5'd7; ld_done_data = 32'hCAFE;
        ex_wr_valid = 1; ex_wr_sel = 5'd6; ex_wr_data = 32'h66;
        expect_wr(5'd6, 32'h66);
        mid();
        check("ld_hz_set", {31'd0, hazard}, 1);
        check("ld_ready_blocked", {31'd0, ld_done_ready}, 0);
        tick();
        ex_wr_valid = 0;
        expect_wr(5'd7, 32'hCAFE);
        mid();
        check("ld_ready_retry", {31'd0, ld_done_ready}, 1);
        check("ld_hz_hold", {31'd0, hazard}, 1);
        tick();
        ld_done_valid = 0;
        mid();
        check("ld_hz_clear", {31'd0, hazard}, 0);

        // Same-cycle issue and completion of x3: set wins
        tick();
        ld_issue = 1; ld_issue_sel = 5'd3; dec_rs1 = 5'd3;
        ld_done_valid = 1; ld_done_sel = 5'd3; ld_done_data = 32'h33;
        expect_wr(5'd3, 32'h33);
        mid();
        check("same_ready", {31'd0, ld_done_ready}, 1);
        tick();
        ld_issue = 0; ld_done_valid = 0;
        mid();
        check("same_set_wins", {31'd0, hazard}, 1);
        tick();
        ld_done_valid = 1; ld_done_sel = 5'd3; ld_done_data = 32'h333;
        expect_wr(5'd3, 32'h333);
        mid();
        tick();
        ld_done_valid = 0; dec_rs1 = 5'd0; dec_rs2 = 5'd3;
        ld_issue = 1; ld_issue_sel = 5'd7;
        mid();
        check("x3_cleared", {31'd0, hazard}, 0);

        // Debug read of x5 held off by the outstanding load to x7
        tick();
        ld_issue = 0; dec_rs2 = 5'd0;
        dbg_req = 1; dbg_we = 0; dbg_sel = 5'd5; core_rs2_sel = 5'd2;
        aq.push_back({1'b1, 32'h1234});
        mid();
        check("dbg_halt_pending", {31'd0, core_halt}, 1);
        check("dbg_idle_rs2sel", {27'd0, bank_rs2_sel}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            mid();
            check("dbg_wait_rs2sel", {27'd0, bank_rs2_sel}, 32'd2);
        end
        tick();
        ld_done_valid = 1; ld_done_sel = 5'd7; ld_done_data = 32'h77;
        expect_wr(5'd7, 32'h77);
        mid();
        check("dbg_wait_ld_ready", {31'd0, ld_done_ready}, 1);
        tick();
        ld_done_valid = 0;
        mid();
        check("dbg_grant_rs2sel", {27'd0, bank_rs2_sel}, 32'd2);
        tick();
        mid();
        check("dbg_access_rs2sel", {27'd0, bank_rs2_sel}, 32'd5);
        check("dbg_access_noack", {31'd0, dbg_ack}, 0);
        tick();
        mid();
        check("dbg_read_ack", {31'd0, dbg_ack}, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            mid();
            check("dbg_no_second_ack", {31'd0, dbg_ack}, 0);
            check("dbg_release_halt", {31'd0, core_halt}, 1);
        end
        tick();
        dbg_req = 0;
        mid();
        check("dbg_release_wait", {31'd0, core_halt}, 1);
        tick();
        mid();
        check("dbg_back_idle", {31'd0, core_halt}, 0);

        // Debug writes and read-back, including x0
        dbg_op(1'b1, 5'd9, 32'hA5A5A5A5, 32'h0);
        dbg_op(1'b1, 5'd0, 32'hFFFFFFFF, 32'h0);
        dbg_op(1'b0, 5'd9, 32'h0, 32'hA5A5A5A5);
        dbg_op(1'b0, 5'd0, 32'h0, 32'h0);

        // Reset asserted during ACCESS aborts without ack
        tick();
        dbg_req = 1; dbg_we = 1; dbg_sel = 5'd10; dbg_wdata = 32'h1010;
        mid();
        tick();
        rst = 0; ld_issue = 1; ld_issue_sel = 5'd4;
        mid();
        check("rst_acc_rs2sel", {27'd0, bank_rs2_sel}, 32'd10);
        check("rst_acc_regw", {31'd0, reg_w}, 0);
        check("rst_acc_ready", {31'd0, ld_done_ready}, 0);
        tick();
        rst = 1; ld_issue = 0; dbg_req = 0; dec_rs1 = 5'd4;
        mid();
        check("rst_abort_ack", {31'd0, dbg_ack}, 0);
        check("rst_abort_halt", {31'd0, core_halt}, 0);
        check("rst_abort_busy", {31'd0, hazard}, 0);
        tick();
        mid();
        check("rst_abort_noack", {31'd0, dbg_ack}, 0);

        check("write_queue_drained", wq.size(), 0);
        check("ack_queue_drained", aq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and load scoreboard for the integer register bank (32 x 32-bit, x0 reads zero). It merges three register-bank writers onto the bank's single write port:
- single-cycle execute writeback
- multi-cycle load completion
- a debug access port

It tracks registers with outstanding loads and raises a decode hazard. It also sequences debug read/write access by halting the core and borrowing the rs2 read port.

## Interface
- BANK_WIDTH, 5, register select width (SIZE = 2**BANK_WIDTH)
- REGISTER_WIDTH, 32, data width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ex_wr_valid  in  1  execute writeback this cycle (never back-pressured)
- ex_wr_sel  in  BANK_WIDTH  execute destination
- ex_wr_data  in  REGISTER_WIDTH  execute result
- ld_issue  in  1  load issued this cycle; marks ld_issue_sel busy
- ld_issue_sel  in  BANK_WIDTH  load destination
- ld_done_valid  in  1  load data available
- ld_done_sel  in  BANK_WIDTH  load destination
- ld_done_data  in  REGISTER_WIDTH  load data
- ld_done_ready  out  1  load writeback accepted this cycle
- dec_rs1, dec_rs2, dec_rd  in  BANK_WIDTH each  decode-stage selects for hazard check
- hazard  out  1  a decode operand/destination is busy
- core_rs2_sel  in  BANK_WIDTH  core rs2 select
- bank_rs2_sel  out  BANK_WIDTH  rs2 select to bank
- bank_rs2_data  in  REGISTER_WIDTH  rs2 data from bank
- reg_w, rd_sel, rd_data  out  1 / BANK_WIDTH / REGISTER_WIDTH  bank write port
- dbg_req, dbg_we  in  1 each  debug request (level, held until ack); write when dbg_we = 1
- dbg_sel, dbg_wdata  in  BANK_WIDTH / REGISTER_WIDTH  debug target and write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  REGISTER_WIDTH  debug read result, registered
- core_halt  out  1  core must stop issuing new instructions

## Operation
- Scoreboard: busy[SIZE-1:0], registered.
  - ld_issue with ld_issue_sel != 0 sets busy[ld_issue_sel].
  - Accepted ld_done (ld_done_valid & ld_done_ready) clears busy[ld_done_sel].
  - Set and clear of the same register in the same cycle: set wins (final busy = 1).
  - busy[0] is constant 0.
- hazard = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd], from registered busy only; a clear is visible the cycle after acceptance.
- Write-port priority, combinational:
  1. Execute: granted whenever ex_wr_valid.
  2. Load: ld_done_ready = ~ex_wr_valid & (state == IDLE).
  3. Debug: writes only in ACCESS.
- reg_w is forced 0 when the selected destination is 0 or rst = 0. Accepted transactions to register 0 still complete (busy clear, dbg_ack).
- bank_rs2_sel = dbg_sel in ACCESS, else core_rs2_sel.
- Debug FSM, states IDLE, ACCESS, ACK, RELEASE:
  - IDLE -> ACCESS when dbg_req & busy == 0 & ~ex_wr_valid & ~ld_done_valid.
  - ACCESS (1 cycle):
    - write: reg_w = (dbg_sel != 0), rd_sel = dbg_sel, rd_data = dbg_wdata.
    - read: dbg_rdata <= bank_rs2_data, or 0 when dbg_sel == 0.
    - -> ACK.
  - ACK: dbg_ack = 1 -> RELEASE.
  - RELEASE: waits for dbg_req = 0 -> IDLE. One access per request level.
- core_halt = dbg_req | (state != IDLE).
- ex_wr_valid or ld_done_valid asserted in ACCESS is a protocol violation. Execute still wins the write port (debug write dropped, ack still given). A bench assertion flags it.

## Timing
- Reset (rst = 0 at posedge): busy = 0, state = IDLE, dbg_ack = 0, dbg_rdata = 0. While rst = 0, reg_w = 0 and ld_done_ready = 0.
- Reset mid-debug: abort to IDLE, no ack.
- Write latency: bank updated at the edge ending the grant cycle.
- Debug latency from grant condition true:
  - ACCESS at +1
  - dbg_ack/dbg_rdata valid at +2
  - RELEASE from +3
- Load completion blocked by execute retries each cycle; ld_done_* must be held stable until ld_done_ready.

## Test plan
- Reset, then ex_wr_valid sel = 5 data = 0x1234 -> reg_w = 1, rd_sel = 5, rd_data = 0x1234 same cycle; sel = 0 -> reg_w = 0.
- ld_issue sel = 7; next cycle dec_rs1 = 7 -> hazard = 1. ld_done sel = 7 data = 0xCAFE with concurrent ex_wr -> ld_done_ready = 0. Following cycle: ready = 1, write 0xCAFE; hazard = 0 one cycle later.
- Same-cycle ld_issue sel = 3 and accepted ld_done sel = 3 -> busy[3] = 1 afterwards.
- dbg_req read sel = 5 with busy[7] set -> core_halt = 1, stays IDLE until load 7 completes. Then ACCESS (bank_rs2_sel = 5), ack next cycle, dbg_rdata = 0x1234; held dbg_req gives no second ack.
- Debug write sel = 9 data = 0xA5A5A5A5 -> reg_w in ACCESS, ack at +2. Debug write sel = 0 -> reg_w = 0, ack still.
- rst low during ACCESS -> next cycle state IDLE, dbg_ack = 0, busy = 0, reg_w = 0.
